// File: rtl/apb_pkg.sv
// Types and helpers shared by the APB master and completer.
// Holds the transfer FSM states, the wait-counter width and byte-lane masking.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } apb_state_e;

    localparam int unsigned CNT_W = 4;

    // Expands one strobe bit per byte lane into a full-width bit mask.
    function automatic logic [63:0] byte_lane_mask(input logic [7:0] strb);
        logic [63:0] mask;
        mask = '0;
        for (int i = 0; i < 8; i++) begin
            mask[i*8 +: 8] = {8{strb[i]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/apb_reg_bank.sv
// Register storage for the APB register file: byte-strobed writes and a
// one-cycle write pulse per register, both visible the cycle after the commit.
module apb_reg_bank
    import apb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 16,
    parameter int IDX_W      = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           we_i,
    input  logic [IDX_W-1:0]               idx_i,
    input  logic [DATA_WIDTH-1:0]          wdata_i,
    input  logic [DATA_WIDTH/8-1:0]        strb_i,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
    output logic [NUM_REGS-1:0]            wr_pulse_o
);

    logic [NUM_REGS*DATA_WIDTH-1:0] regs_q, regs_d;
    logic [NUM_REGS-1:0]            pulse_q, pulse_d;
    logic [DATA_WIDTH-1:0]          lane_mask;

    always_comb begin
        regs_d    = regs_q;
        pulse_d   = '0;
        lane_mask = DATA_WIDTH'(byte_lane_mask(8'(strb_i)));
        // The range guard only matters when NUM_REGS is not a power of two.
        if (we_i && (int'(idx_i) < NUM_REGS)) begin
            regs_d[idx_i*DATA_WIDTH +: DATA_WIDTH] =
                (regs_q[idx_i*DATA_WIDTH +: DATA_WIDTH] & ~lane_mask) |
                (wdata_i & lane_mask);
            pulse_d[idx_i] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q  <= '0;
            pulse_q <= '0;
        end else begin
            regs_q  <= regs_d;
            pulse_q <= pulse_d;
        end
    end

    assign regs_o     = regs_q;
    assign wr_pulse_o = pulse_q;

endmodule

// File: rtl/apb_slave_regfile.sv
// APB4 completer mapping transfers onto a bank of word-sized registers, with
// configurable wait states and PSLVERR on misaligned or out-of-range addresses.
module apb_slave_regfile
    import apb_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    NUM_REGS    = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int                    WAIT_CYCLES = 0
) (
    input  logic                           pclk_i,
    input  logic                           prstn_i,
    input  logic [ADDR_WIDTH-1:0]          paddr_i,
    input  logic [2:0]                     pprot_i,
    input  logic                           psel_i,
    input  logic                           penable_i,
    input  logic                           pwrite_i,
    input  logic [DATA_WIDTH-1:0]          pwdata_i,
    input  logic [DATA_WIDTH/8-1:0]        pstrb_i,
    output logic                           pready_o,
    output logic [DATA_WIDTH-1:0]          prdata_o,
    output logic                           pslverr_o,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
    output logic [NUM_REGS-1:0]            wr_pulse_o
);

    localparam int STRB_W     = DATA_WIDTH / 8;
    localparam int LANE_SHIFT = $clog2(STRB_W);
    localparam int IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    apb_state_e              state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    write_q, write_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]       strb_q, strb_d;
    logic                    err_q, err_d;
    logic [IDX_W-1:0]        idx_q, idx_d;

    logic [ADDR_WIDTH-1:0]   offset;
    logic [ADDR_WIDTH-1:0]   index_full;
    logic                    dec_err;
    logic                    setup;
    logic                    pready;
    logic                    commit;
    logic [DATA_WIDTH-1:0]   rd_word;
    logic                    unused_prot;

    assign unused_prot = ^pprot_i;

    // Unsigned wrap makes addresses below the base land far out of range.
    always_comb begin
        offset     = paddr_i - BASE_ADDR;
        index_full = offset >> LANE_SHIFT;
        dec_err    = (index_full >= ADDR_WIDTH'(NUM_REGS)) ||
                     (offset[LANE_SHIFT-1:0] != '0);
    end

    assign setup = psel_i & ~penable_i;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        wdata_d = wdata_q;
        strb_d  = strb_q;
        err_d   = err_q;
        idx_d   = idx_q;
        pready  = 1'b0;

        case (state_q)
            IDLE: begin
                if (setup) state_d = ACCESS;
            end
            ACCESS: begin
                pready = psel_i & penable_i & (cnt_q == '0);
                if (!psel_i) begin
                    state_d = IDLE;
                end else if (pready) begin
                    state_d = DONE;
                end else if (penable_i && (cnt_q != '0)) begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                state_d = setup ? ACCESS : IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A setup phase seen in IDLE or DONE captures the whole request.
        if ((state_q != ACCESS) && setup) begin
            cnt_d   = CNT_W'(WAIT_CYCLES);
            write_d = pwrite_i;
            wdata_d = pwdata_i;
            strb_d  = pstrb_i;
            err_d   = dec_err;
            idx_d   = index_full[IDX_W-1:0];
        end
    end

    always_ff @(posedge pclk_i or negedge prstn_i) begin
        if (!prstn_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            strb_q  <= '0;
            err_q   <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            strb_q  <= strb_d;
            err_q   <= err_d;
            idx_q   <= idx_d;
        end
    end

    assign commit = pready & write_q & ~err_q;

    apb_reg_bank #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .IDX_W      (IDX_W)
    ) u_reg_bank (
        .clk        (pclk_i),
        .rst_n      (prstn_i),
        .we_i       (commit),
        .idx_i      (idx_q),
        .wdata_i    (wdata_q),
        .strb_i     (strb_q),
        .regs_o     (regs_o),
        .wr_pulse_o (wr_pulse_o)
    );

    assign rd_word   = regs_o[idx_q*DATA_WIDTH +: DATA_WIDTH];
    assign pready_o  = pready;
    assign pslverr_o = pready & err_q;
    assign prdata_o  = (pready && !err_q) ? rd_word : '0;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Bench for apb_slave_regfile: two instances (no wait states at base 0, three
// wait states at base 0x100), directed cases plus random traffic vs a model.
module tb_apb_slave_regfile;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NR = 16;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [AW-1:0]   paddr;
    logic [2:0]      pprot;
    logic [1:0]      psel;
    logic            penable;
    logic            pwrite;
    logic [DW-1:0]   pwdata;
    logic [DW/8-1:0] pstrb;

    logic [1:0]      pready;
    logic [1:0]      pslverr;
    logic [DW-1:0]   prdata   [2];
    logic [NR*DW-1:0] regs    [2];
    logic [NR-1:0]   wr_pulse [2];

    int              checks = 0;
    int              errors = 0;

    logic [31:0]     mdl [2][NR];
    int              wait_cfg [2] = '{0, 3};
    logic [31:0]     base_cfg [2] = '{32'h0, 32'h100};

    always #5 clk = ~clk;

    apb_slave_regfile #(
        .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .NUM_REGS (NR),
        .BASE_ADDR  (32'h0), .WAIT_CYCLES (0)
    ) dut0 (
        .pclk_i (clk), .prstn_i (rst_n), .paddr_i (paddr), .pprot_i (pprot),
        .psel_i (psel[0]), .penable_i (penable), .pwrite_i (pwrite),
        .pwdata_i (pwdata), .pstrb_i (pstrb), .pready_o (pready[0]),
        .prdata_o (prdata[0]), .pslverr_o (pslverr[0]), .regs_o (regs[0]),
        .wr_pulse_o (wr_pulse[0])
    );

    apb_slave_regfile #(
        .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .NUM_REGS (NR),
        .BASE_ADDR  (32'h100), .WAIT_CYCLES (3)
    ) dut1 (
        .pclk_i (clk), .prstn_i (rst_n), .paddr_i (paddr), .pprot_i (pprot),
        .psel_i (psel[1]), .penable_i (penable), .pwrite_i (pwrite),
        .pwdata_i (pwdata), .pstrb_i (pstrb), .pready_o (pready[1]),
        .prdata_o (prdata[1]), .pslverr_o (pslverr[1]), .regs_o (regs[1]),
        .wr_pulse_o (wr_pulse[1])
    );

    task automatic check_val(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic model_err(input int k, input logic [31:0] a);
        logic [31:0] off;
        off = a - base_cfg[k];
        return (off % 4 != 0) || (off >= 32'(NR * 4));
    endfunction

    function automatic int model_idx(input int k, input logic [31:0] a);
        logic [31:0] off;
        off = a - base_cfg[k];
        return int'(off / 4);
    endfunction

    function automatic logic [NR*DW-1:0] model_flat(input int k);
        logic [NR*DW-1:0] f;
        for (int i = 0; i < NR; i++) f[i*DW +: DW] = mdl[k][i];
        return f;
    endfunction

    function automatic logic [31:0] model_merge(input logic [31:0] old, input logic [31:0] d,
                                                input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < NR; i++) mdl[k][i] = '0;
    endtask

    task automatic bus_idle();
        @(posedge clk); #1;
        psel    = '0;
        penable = 1'b0;
    endtask

    // Runs setup and access phases; returns at the negedge of the ready cycle.
    task automatic apb_xfer(input int k, input logic [31:0] a, input logic w,
                            input logic [31:0] d, input logic [3:0] s,
                            output logic [31:0] rd, output logic er, output int ncyc);
        logic seen;
        @(posedge clk); #1;
        psel    = '0;
        psel[k] = 1'b1;
        penable = 1'b0;
        paddr   = a;
        pwrite  = w;
        pwdata  = d;
        pstrb   = s;
        pprot   = 3'($urandom_range(0, 7));
        ncyc    = 1;
        @(posedge clk); #1;
        penable = 1'b1;
        ncyc    = 2;
        seen    = 1'b0;
        for (int g = 0; g < 40; g++) begin
            @(negedge clk);
            if (pready[k]) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk); #1;
            ncyc++;
        end
        if (!seen) check_val("pready_timeout", 0, 1);
        rd = prdata[k];
        er = pslverr[k];
    endtask

    task automatic do_xfer(input int k, input logic [31:0] a, input logic w,
                           input logic [31:0] d, input logic [3:0] s,
                           output logic [31:0] rd);
        logic        exp_err;
        logic        er;
        int          n;
        int          idx;
        logic [31:0] exp_rd;
        logic [NR-1:0] exp_pulse;
        exp_err   = model_err(k, a);
        idx       = exp_err ? 0 : model_idx(k, a);
        exp_rd    = (!exp_err && !w) ? mdl[k][idx] : 32'h0;
        exp_pulse = '0;
        apb_xfer(k, a, w, d, s, rd, er, n);
        check_val("pslverr", er, exp_err);
        check_val("cycles", n, 2 + wait_cfg[k]);
        if (!w || exp_err) check_val("prdata", rd, exp_rd);
        if (w && !exp_err) begin
            mdl[k][idx]    = model_merge(mdl[k][idx], d, s);
            exp_pulse[idx] = 1'b1;
        end
        bus_idle();
        @(negedge clk);
        check_val("wr_pulse", wr_pulse[k], exp_pulse);
        check_val("wr_pulse_other", wr_pulse[1-k], 0);
        check_val("regs", regs[k], model_flat(k));
    endtask

    task automatic random_traffic(input int count);
        int          k;
        int          sel;
        logic [31:0] a;
        logic [31:0] rd;
        for (int t = 0; t < count; t++) begin
            k   = $urandom_range(0, 1);
            sel = $urandom_range(0, 9);
            if (sel < 7)       a = base_cfg[k] + 32'(4 * $urandom_range(0, NR - 1));
            else if (sel == 7) a = base_cfg[k] + 32'(4 * $urandom_range(0, NR - 1))
                                   + 32'($urandom_range(1, 3));
            else if (sel == 8) a = base_cfg[k] + 32'(NR * 4) + 32'(4 * $urandom_range(0, 7));
            else               a = base_cfg[k] - 32'(4 * $urandom_range(1, 4));
            do_xfer(k, a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)), rd);
        end
    endtask

    initial begin
        logic [31:0] rd, rd2;
        logic        er, er2;
        int          n, n2;

        rst_n   = 1'b0;
        psel    = '0;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = '0;
        pwdata  = '0;
        pstrb   = '0;
        pprot   = '0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check_val("rst_pready", pready[k], 0);
            check_val("rst_pslverr", pslverr[k], 0);
            check_val("rst_prdata", prdata[k], 0);
            check_val("rst_regs", regs[k], 0);
            check_val("rst_wr_pulse", wr_pulse[k], 0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Directed: full write, readback, strobed write, error addresses.
        do_xfer(0, 32'h8, 1'b1, 32'hDEADBEEF, 4'hF, rd);
        do_xfer(0, 32'h8, 1'b0, 32'h0, 4'h0, rd);
        check_val("read_reg2", rd, 32'hDEADBEEF);
        do_xfer(0, 32'h8, 1'b1, 32'h11223344, 4'b0101, rd);
        do_xfer(0, 32'h8, 1'b0, 32'h0, 4'h0, rd);
        check_val("read_reg2_strobed", rd, 32'hDE22BE44);
        do_xfer(0, 32'h40, 1'b1, 32'hCAFEF00D, 4'hF, rd);
        do_xfer(0, 32'h6, 1'b1, 32'hCAFEF00D, 4'hF, rd);
        do_xfer(0, 32'h20, 1'b1, 32'hA5A5A5A5, 4'h0, rd);

        // Wait states: read on the 3-wait instance, plus a write that wraps below base.
        do_xfer(1, 32'h104, 1'b1, 32'h0BADF00D, 4'hF, rd);
        do_xfer(1, 32'h104, 1'b0, 32'h0, 4'h0, rd);
        check_val("read_wait3", rd, 32'h0BADF00D);
        do_xfer(1, 32'hFC, 1'b1, 32'h12345678, 4'hF, rd);

        // Back-to-back: second setup lands in the DONE cycle of the first.
        apb_xfer(0, 32'h0, 1'b1, 32'h1, 4'hF, rd, er, n);
        mdl[0][0] = 32'h1;
        apb_xfer(0, 32'h0, 1'b0, 32'h0, 4'h0, rd2, er2, n2);
        check_val("b2b_first_cycles", n, 2);
        check_val("b2b_second_cycles", n2, 2);
        check_val("b2b_read", rd2, 32'h1);
        check_val("b2b_err", {er, er2}, 0);
        bus_idle();
        @(negedge clk);
        check_val("b2b_regs", regs[0], model_flat(0));

        random_traffic(60);

        // Abort: psel drops during wait states on the 3-wait instance.
        @(posedge clk); #1;
        psel    = 2'b10;
        penable = 1'b0;
        paddr   = 32'h108;
        pwrite  = 1'b1;
        pwdata  = 32'hFFFF0000;
        pstrb   = 4'hF;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check_val("abort_pready", pready[1], 0);
        bus_idle();
        repeat (4) begin
            @(negedge clk);
            check_val("abort_wr_pulse", wr_pulse[1], 0);
            check_val("abort_regs", regs[1], model_flat(1));
        end
        do_xfer(1, 32'h108, 1'b0, 32'h0, 4'h0, rd);

        // Reset asserted in the middle of a waited write.
        @(posedge clk); #1;
        psel    = 2'b10;
        penable = 1'b0;
        paddr   = 32'h10C;
        pwrite  = 1'b1;
        pwdata  = 32'h55AA55AA;
        pstrb   = 4'hF;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        for (int k = 0; k < 2; k++) begin
            check_val("midrst_pready", pready[k], 0);
            check_val("midrst_pslverr", pslverr[k], 0);
            check_val("midrst_prdata", prdata[k], 0);
            check_val("midrst_regs", regs[k], 0);
            check_val("midrst_wr_pulse", wr_pulse[k], 0);
        end
        psel    = '0;
        penable = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        do_xfer(1, 32'h10C, 1'b0, 32'h0, 4'h0, rd);
        do_xfer(0, 32'h8, 1'b0, 32'h0, 4'h0, rd);

        random_traffic(40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "simulation did not finish");
    end

endmodule
